// File: rtl/morse_decoder.sv
// rtl/morse_decoder.sv - Morse receive decoder: mark/gap run classification into code/length characters.
// Define MORSE_DEC_ERR_EN to enable illegal-mark and symbol-overflow detection on sym_err.
module morse_decoder #(
  parameter int MAX_SYM   = 8,
  parameter int CHAR_GAP  = 3,
  parameter int SPACE_GAP = 7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               led_in,
  output logic               char_vald,
  output logic [MAX_SYM-1:0] charcode_data,
  output logic [3:0]         charlen_data,
  input  logic               char_rdy,
  output logic               sym_err,
  output logic               ovr
);
  localparam logic [3:0] MAX_SYM_C   = 4'(MAX_SYM);
  localparam logic [3:0] CHAR_GAP_C  = 4'(CHAR_GAP);
  localparam logic [3:0] SPACE_GAP_C = 4'(SPACE_GAP);

  typedef enum logic [1:0] {S_IDLE, S_MARK, S_GAP, S_WGAP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         mark_cnt_q, mark_cnt_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;
  logic [3:0]         sym_n_q, sym_n_d;
  logic [MAX_SYM-1:0] sym_sr_q, sym_sr_d;
  logic [MAX_SYM-1:0] code_q, code_d;
  logic [3:0]         len_q, len_d;
  logic               vald_q, vald_d;
  logic               ovr_q, ovr_d;
  logic [3:0]         mark_inc, gap_inc;
  logic               sym_dash, sym_bad;
  logic [MAX_SYM-1:0] sym_bit;
  logic               cmp, load;
  logic [MAX_SYM-1:0] cmp_code;
  logic [3:0]         cmp_len;
`ifdef MORSE_DEC_ERR_EN
  logic               err_q, err_d;
`endif

  assign mark_inc = (mark_cnt_q == 4'hF) ? 4'hF : mark_cnt_q + 4'd1;
  assign gap_inc  = (gap_cnt_q == 4'hF) ? 4'hF : gap_cnt_q + 4'd1;

`ifdef MORSE_DEC_ERR_EN
  assign sym_dash = (mark_cnt_q == 4'd3);
  assign sym_bad  = !((mark_cnt_q == 4'd1) || sym_dash) || (sym_n_q == MAX_SYM_C);
`else
  assign sym_dash = (mark_cnt_q >= 4'd3);
  assign sym_bad  = 1'b0;
`endif

  // Dots leave their slot at 0, so only a dash needs to be OR-ed in.
  assign sym_bit = {sym_dash, {(MAX_SYM-1){1'b0}}} >> sym_n_q;

  always_comb begin
    state_d    = state_q;
    mark_cnt_d = mark_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    sym_n_d    = sym_n_q;
    sym_sr_d   = sym_sr_q;
    cmp        = 1'b0;
    cmp_code   = '0;
    cmp_len    = 4'd0;
`ifdef MORSE_DEC_ERR_EN
    err_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (led_in) begin
          state_d    = S_MARK;
          mark_cnt_d = 4'd1;
        end
      end
      S_MARK: begin
        if (led_in) begin
          mark_cnt_d = mark_inc;
        end else begin
          if (sym_bad) begin
`ifdef MORSE_DEC_ERR_EN
            err_d = 1'b1;
`endif
            sym_sr_d = '0;
            sym_n_d  = 4'd0;
          end else if (sym_n_q < MAX_SYM_C) begin
            sym_sr_d = sym_sr_q | sym_bit;
            sym_n_d  = sym_n_q + 4'd1;
          end
          mark_cnt_d = 4'd0;
          gap_cnt_d  = 4'd1;
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        if (led_in) begin
          state_d    = S_MARK;
          mark_cnt_d = 4'd1;
        end else begin
          gap_cnt_d = gap_inc;
          if (gap_inc == CHAR_GAP_C) begin
            // An empty character only follows an error; it ends the run without a space.
            if (sym_n_q != 4'd0) begin
              cmp      = 1'b1;
              cmp_code = sym_sr_q;
              cmp_len  = sym_n_q;
              state_d  = S_WGAP;
            end else begin
              state_d  = S_IDLE;
            end
            sym_sr_d = '0;
            sym_n_d  = 4'd0;
          end
        end
      end
      S_WGAP: begin
        if (led_in) begin
          state_d    = S_MARK;
          mark_cnt_d = 4'd1;
        end else begin
          gap_cnt_d = gap_inc;
          if (gap_inc == SPACE_GAP_C) begin
            cmp     = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vald_d = vald_q;
    code_d = code_q;
    len_d  = len_q;
    ovr_d  = ovr_q;
    load   = cmp && (!vald_q || char_rdy);
    if (load) begin
      vald_d = 1'b1;
      code_d = cmp_code;
      len_d  = cmp_len;
    end else begin
      if (cmp)
        ovr_d = 1'b1;
      if (vald_q && char_rdy)
        vald_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      mark_cnt_q <= 4'd0;
      gap_cnt_q  <= 4'd0;
      sym_n_q    <= 4'd0;
      sym_sr_q   <= '0;
      code_q     <= '0;
      len_q      <= 4'd0;
      vald_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mark_cnt_q <= mark_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      sym_n_q    <= sym_n_d;
      sym_sr_q   <= sym_sr_d;
      code_q     <= code_d;
      len_q      <= len_d;
      vald_q     <= vald_d;
      ovr_q      <= ovr_d;
    end
  end

`ifdef MORSE_DEC_ERR_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign sym_err = err_q;
`else
  assign sym_err = 1'b0;
`endif

  assign char_vald     = vald_q;
  assign charcode_data = code_q;
  assign charlen_data  = len_q;
  assign ovr           = ovr_q;
endmodule

// File: tb/tb_morse_decoder.sv
// tb/tb_morse_decoder.sv - Scoreboard bench for morse_decoder against a run-length reference model.
module tb_morse_decoder;
  localparam int MAX_SYM   = 8;
  localparam int CHAR_GAP  = 3;
  localparam int SPACE_GAP = 7;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       led_in = 1'b0;
  logic       char_rdy = 1'b0;
  logic       char_vald;
  logic [7:0] charcode_data;
  logic [3:0] charlen_data;
  logic       sym_err;
  logic       ovr;

  morse_decoder #(.MAX_SYM(MAX_SYM), .CHAR_GAP(CHAR_GAP), .SPACE_GAP(SPACE_GAP)) dut (
    .clock(clock), .reset(reset), .led_in(led_in), .char_vald(char_vald),
    .charcode_data(charcode_data), .charlen_data(charlen_data), .char_rdy(char_rdy),
    .sym_err(sym_err), .ovr(ovr)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] code;
    logic [3:0] len;
    int         c;
  } ent_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          err_cnt = 0;
  int          last_cyc = 0;
  bit          mon_en = 1'b0;
  logic [11:0] exp_q[$];
  ent_t        log_q[$];
  bit          exp_vald, exp_err, exp_ovr;
  bit          pend_vald, pend_err, pend_ovr;

  // Reference model state: lengths of the current mark and blank runs plus the pending symbols.
  int m_run = 0;
  int m_blank = 0;
  bit m_active = 1'b0;
  bit m_vald = 1'b0;
  bit m_ovr = 1'b0;
  bit syms[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  task automatic model_edge(input bit x, input bit r);
    bit         cmp = 1'b0;
    bit         err = 1'b0;
    logic [7:0] code = '0;
    logic [3:0] len = '0;
    if (x) begin
      m_run++;
      m_blank = 0;
    end else if (m_run > 0) begin
`ifdef MORSE_DEC_ERR_EN
      if ((m_run == 1 || m_run == 3) && syms.size() < MAX_SYM) syms.push_back(m_run == 3);
      else begin
        err = 1'b1;
        syms.delete();
      end
`else
      if (syms.size() < MAX_SYM) syms.push_back(m_run >= 3);
`endif
      m_run = 0;
      m_blank = 1;
      m_active = 1'b1;
    end else if (m_active) begin
      m_blank++;
      if (m_blank == CHAR_GAP) begin
        if (syms.size() > 0) begin
          cmp = 1'b1;
          len = 4'(syms.size());
          foreach (syms[i]) code[7-i] = syms[i];
        end else begin
          m_active = 1'b0;
        end
        syms.delete();
      end else if (m_blank == SPACE_GAP) begin
        cmp = 1'b1;
        m_active = 1'b0;
      end
    end
    if (cmp) begin
      if (!m_vald || r) begin
        exp_q.push_back({code, len});
        m_vald = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_vald && r) begin
      m_vald = 1'b0;
    end
    pend_vald = m_vald;
    pend_err  = err;
    pend_ovr  = m_ovr;
  endtask

  task automatic step(input bit x, input bit r);
    @(posedge clock);
    exp_vald = pend_vald;
    exp_err  = pend_err;
    exp_ovr  = pend_ovr;
    #1;
    led_in   = x;
    char_rdy = r;
    last_cyc = cyc;
    model_edge(x, r);
  endtask

  task automatic marks(input int n, input bit r);
    repeat (n) step(1'b1, r);
  endtask

  task automatic blanks(input int n, input bit r);
    repeat (n) step(1'b0, r);
  endtask

  task automatic send_char(input int n, input logic [15:0] pat, input bit r);
    for (int i = 0; i < n; i++) begin
      marks(pat[15-i] ? 3 : 1, r);
      if (i < n - 1) blanks(1, r);
    end
  endtask

  task automatic do_reset(input int hold);
    #2 reset = 1'b0;
    #1;
    check("rst_vald", char_vald, 0);
    check("rst_code", charcode_data, 0);
    check("rst_len", charlen_data, 0);
    check("rst_err", sym_err, 0);
    check("rst_ovr", ovr, 0);
    m_run = 0; m_blank = 0; m_active = 1'b0; m_vald = 1'b0; m_ovr = 1'b0;
    syms.delete();
    exp_q.delete();
    pend_vald = 1'b0; pend_err = 1'b0; pend_ovr = 1'b0;
    exp_vald = 1'b0; exp_err = 1'b0; exp_ovr = 1'b0;
    led_in = 1'b0;
    char_rdy = 1'b0;
    repeat (hold) @(posedge clock);
    #3 reset = 1'b1;
  endtask

  function automatic bit rnd_rdy();
    return $urandom_range(0, 3) != 0;
  endfunction

  always @(negedge clock) begin
    if (mon_en && reset) begin
      check("char_vald", char_vald, exp_vald);
      check("sym_err", sym_err, exp_err);
      check("ovr", ovr, exp_ovr);
      if (sym_err) err_cnt++;
      if (char_vald && char_rdy) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_char: got %0h expected none", {charcode_data, charlen_data});
        end else begin
          check("char_out", {charcode_data, charlen_data}, exp_q.pop_front());
        end
        log_q.push_back('{charcode_data, charlen_data, cyc});
      end
    end
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int mark_edge;
    int mlen;
    int g;
    #1;
    do_reset(3);
    mon_en = 1'b1;

    // 'M' with latency from the last mark edge, then the trailing space
    log_q.delete();
    send_char(2, 16'hC000, 1'b1);
    mark_edge = last_cyc + 1;
    blanks(10, 1'b1);
    check("m_count", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check("m_char", {log_q[0].code, log_q[0].len}, {8'hC0, 4'd2});
      check("m_latency", log_q[0].c - mark_edge, 3);
      check("m_space", {log_q[1].code, log_q[1].len}, 12'h000);
    end

    // 'T', word space, 'A'
    log_q.delete();
    send_char(1, 16'h8000, 1'b1);
    blanks(7, 1'b1);
    send_char(2, 16'h4000, 1'b1);
    blanks(10, 1'b1);
    check("tsa_count", log_q.size(), 4);
    if (log_q.size() >= 3) begin
      check("tsa_t", {log_q[0].code, log_q[0].len}, {8'h80, 4'd1});
      check("tsa_space", {log_q[1].code, log_q[1].len}, 12'h000);
      check("tsa_a", {log_q[2].code, log_q[2].len}, {8'h40, 4'd2});
    end

    // two-cycle mark, then 'E'
    log_q.delete();
    e0 = err_cnt;
    marks(2, 1'b1);
    blanks(10, 1'b1);
`ifdef MORSE_DEC_ERR_EN
    check("mark2_err", err_cnt - e0, 1);
    check("mark2_nochar", log_q.size(), 0);
`else
    check("mark2_err", err_cnt - e0, 0);
    check("mark2_count", log_q.size(), 2);
    if (log_q.size() >= 1) check("mark2_dot", {log_q[0].code, log_q[0].len}, 12'h001);
`endif
    log_q.delete();
    marks(1, 1'b1);
    blanks(10, 1'b1);
    check("e_count", log_q.size(), 2);
    if (log_q.size() >= 1) check("e_char", {log_q[0].code, log_q[0].len}, 12'h001);

    // nine dots
    log_q.delete();
    e0 = err_cnt;
    send_char(9, 16'h0000, 1'b1);
    blanks(10, 1'b1);
`ifdef MORSE_DEC_ERR_EN
    check("nine_err", err_cnt - e0, 1);
    check("nine_nochar", log_q.size(), 0);
`else
    check("nine_err", err_cnt - e0, 0);
    check("nine_count", log_q.size(), 2);
    if (log_q.size() >= 1) check("nine_char", {log_q[0].code, log_q[0].len}, 12'h008);
`endif

    // overrun: 'E' held while 'T' completes
    log_q.delete();
    marks(1, 1'b0);
    blanks(3, 1'b0);
    marks(3, 1'b0);
    blanks(4, 1'b0);
    check("ovr_set", ovr, 1);
    check("ovr_hold_vald", char_vald, 1);
    check("ovr_hold_data", {charcode_data, charlen_data}, 12'h001);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("ovr_accept_vald", char_vald, 0);
    check("ovr_accept_count", log_q.size(), 1);
    if (log_q.size() >= 1) check("ovr_accept_e", {log_q[0].code, log_q[0].len}, 12'h001);
    blanks(10, 1'b1);

    // reset in the middle of a dash
    marks(1, 1'b1);
    blanks(1, 1'b1);
    marks(3, 1'b1);
    do_reset(2);
    log_q.delete();
    send_char(2, 16'h4000, 1'b1);
    blanks(10, 1'b1);
    check("post_rst_count", log_q.size(), 2);
    if (log_q.size() >= 1) check("post_rst_a", {log_q[0].code, log_q[0].len}, {8'h40, 4'd2});
    check("post_rst_ovr", ovr, 0);

    // randomized marks, gaps and back-pressure
    repeat (250) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: mlen = 1;
        4, 5, 6, 7: mlen = 3;
        8:          mlen = 2;
        default:    mlen = $urandom_range(4, 6);
      endcase
      for (int i = 0; i < mlen; i++) step(1'b1, rnd_rdy());
      g = $urandom_range(0, 9);
      if (g < 5)      g = 1;
      else if (g < 8) g = $urandom_range(2, 6);
      else            g = $urandom_range(7, 10);
      for (int i = 0; i < g; i++) step(1'b0, rnd_rdy());
      if ($urandom_range(0, 99) == 0) do_reset(1);
    end

    blanks(12, 1'b1);
    @(negedge clock);
    check("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/morse_decoder.md
# morse_decoder

Receive-side counterpart of the Morse transmitter. Samples the single-bit LED/key line once per clock, classifies mark and gap run lengths into dots, dashes, character boundaries and word spaces, and reassembles each character into the same code/length format the transmitter consumes. Results go to a downstream character consumer through a one-entry valid/ready output buffer.

## Interface
- MAX_SYM, 8: maximum symbols per character; also the width of charcode_data.
- CHAR_GAP, 3: consecutive blank cycles that end a character.
- SPACE_GAP, 7: consecutive blank cycles, counted from the end of the last mark, that produce a word space.
- clock  input  1  rising-edge clock; one cycle is one Morse unit.
- reset  input  1  asynchronous, active-low reset.
- led_in  input  1  mark line; 1 = LED on.
- char_vald  output  1  output buffer holds a character.
- charcode_data  output  8  symbols, MSB first, left-aligned at bit 7; dash = 1, dot = 0; unused low bits are 0.
- charlen_data  output  4  symbol count 0..8; 0 with code 0 means word space.
- char_rdy  input  1  consumer accepts the buffer when char_vald && char_rdy.
- sym_err  output  1  one-cycle pulse on a malformed mark or symbol overflow.
- ovr  output  1  sticky; a completed character was dropped because the buffer was full.

## Operation
- Reset values: char_vald=0, charcode_data=0, charlen_data=0, sym_err=0, ovr=0. FSM is in IDLE. Counters and the shift register are 0.
- Run counters mark_cnt and gap_cnt are 4 bits wide and saturate at 15.
- Shift register sym_sr[7:0] and symbol count sym_n[3:0].
- **IDLE**: led_in=1 moves to MARK with mark_cnt=1. Blank cycles are ignored, so no space is produced before the first character.
- **MARK**: mark_cnt increments while led_in=1. On the first cycle with led_in=0, the mark is classified:
  - mark_cnt=1 is a dot.
  - mark_cnt=3 is a dash.
  - Any other count is an error.
  - A valid symbol writes bit 7-sym_n of sym_sr and increments sym_n. The FSM then moves to GAP with gap_cnt=1.
- **GAP**: led_in=1 with gap_cnt<CHAR_GAP returns to MARK, which is an intra-character gap. When gap_cnt reaches CHAR_GAP, the character {sym_sr, sym_n} is completed. The FSM then clears sym_sr/sym_n and moves to WGAP, with gap_cnt continuing to count.
- **WGAP**: led_in=1 goes to MARK, with no space emitted. When gap_cnt reaches SPACE_GAP, a space {0,0} is completed and the FSM moves to IDLE. Exactly one space is emitted per gap, however long the gap is.
- **Error handling**: covers an illegal mark length, or a 9th symbol when sym_n=MAX_SYM. sym_err pulses, the partial character is discarded (sym_sr/sym_n cleared), and the FSM waits in GAP with no completion. A subsequent CHAR_GAP completion with sym_n=0 is suppressed and does not produce a space.
- **Output buffer load**: a completion loads the buffer if char_vald=0, or if char_vald && char_rdy in the same cycle (accept and refill together).
  - Otherwise the completion is dropped and ovr is set.
  - char_vald clears on accept when there is no simultaneous load.
  - charcode_data and charlen_data are stable while char_vald=1.
- **Reset mid-operation**: asserting reset aborts any partial character, clears the buffer and ovr, and returns to IDLE. The next mark is decoded from scratch.

## Timing
- Completion latency: char_vald rises on the same edge that samples the CHAR_GAP-th consecutive 0 after a mark. With default parameters, that is 3 cycles after the last mark cycle.
- Space latency: char_vald rises on the edge that samples the SPACE_GAP-th consecutive 0 after the final mark. The preceding character must have been accepted by then, or ovr is set.
- sym_err is asserted on the edge that samples the first 0 after the offending mark, or on the edge that classifies the 9th symbol.
- Throughput: one character per cycle through the buffer when char_rdy is held high.

## Configuration
- MORSE_DEC_ERR_EN defined:
  - Illegal mark lengths and overflow are detected as described under Operation.
  - sym_err is driven.
- MORSE_DEC_ERR_EN undefined:
  - sym_err is tied 0.
  - Marks of 1–2 cycles decode as dot; marks of 3 or more cycles decode as dash.
  - Symbols beyond MAX_SYM are silently dropped and sym_n saturates at 8. The character is still completed.

## Test plan
- Reset low, then high. Drive 'M' (mark 3, blank 1, mark 3, blank 3) with char_rdy=1. Expect char_vald for 1 cycle with code 1100_0000, len 2, exactly 3 cycles after the last mark.
- 'T', then 7 blanks, then 'A' (mark 1, blank 1, mark 3). Expect three outputs in order:
  - 1000_0000, len 1 ('T').
  - A space {0000_0000, 0}.
  - 0100_0000, len 2 ('A').
- Mark of 2 cycles with MORSE_DEC_ERR_EN defined. Expect a sym_err pulse and no character output. Then 'E' (mark 1) decodes to 0000_0000, len 1.
- Hold char_rdy=0 and send 'E', then 'T'. Expect 'E' to stay latched and ovr=1 after the 'T' completion. Then raise char_rdy; 'E' is accepted and char_vald falls.
- Nine dots with 1-cycle gaps:
  - With MORSE_DEC_ERR_EN: sym_err pulses at the 9th dot and there is no output.
  - Without it: the output is 0000_0000, len 8.
- Drop reset to 0 during a dash mid-character. All outputs read 0 immediately. After release, 'A' decodes correctly.
